// File: rtl/ysyx_23060096_pkg.sv
// Shared types and constants for the NPC write-back stage.
// The request struct is sized for the default register-file geometry.
package ysyx_23060096_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;
  localparam int NUM_REGS  = 1 << WB_ADDR_W;
  localparam int REG_ZERO  = 0;

  // Bit positions inside the one-hot grant vector.
  localparam int GNT_EXU = 0;
  localparam int GNT_LSU = 1;

  typedef struct packed {
    logic                 wen;
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

  // x0 is hardwired, so a request only touches the register file when it
  // both wants to write and targets a non-zero register.
  function automatic logic writes_rd(input wb_req_t r);
    return r.wen && (r.rd != WB_ADDR_W'(REG_ZERO));
  endfunction

endpackage

// File: rtl/ysyx_23060096_wbu_if.sv
// Result-delivery bundle from the EXU and LSU into the write-back unit.
interface ysyx_23060096_wbu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);

  // Handshake: a transfer happens on the rising edge where x_valid & x_ready.
  // A source raising x_valid keeps valid and its wen/rd/data stable until it
  // sees x_ready; x_ready is combinational and never high for both sources.
  logic                  exu_valid;
  logic                  exu_wen;
  logic [ADDR_WIDTH-1:0] exu_rd;
  logic [DATA_WIDTH-1:0] exu_data;
  logic                  exu_ready;

  logic                  lsu_valid;
  logic                  lsu_wen;
  logic [ADDR_WIDTH-1:0] lsu_rd;
  logic [DATA_WIDTH-1:0] lsu_data;
  logic                  lsu_ready;

  modport master (
    output exu_valid, exu_wen, exu_rd, exu_data,
    output lsu_valid, lsu_wen, lsu_rd, lsu_data,
    input  exu_ready, lsu_ready
  );

  modport slave (
    input  exu_valid, exu_wen, exu_rd, exu_data,
    input  lsu_valid, lsu_wen, lsu_rd, lsu_data,
    output exu_ready, lsu_ready
  );

endinterface

// File: rtl/ysyx_23060096_wb_arbiter.sv
// Two-input arbiter: LSU wins contention unless the EXU has been denied
// STARVE_LIMIT times in a row, in which case the EXU wins once.
module ysyx_23060096_wb_arbiter
  import ysyx_23060096_pkg::*;
#(
  parameter int STARVE_LIMIT = 3,
  parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             hold,
  input  logic             exu_valid,
  input  logic             lsu_valid,
  output logic [1:0]       grant,
  output logic [CNT_W-1:0] starve_cnt
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic exu_priority;

  always_comb begin
    grant        = '0;
    exu_priority = (starve_cnt == LIMIT);
    if (rstn && !hold) begin
      if (exu_valid && (!lsu_valid || exu_priority)) begin
        grant[GNT_EXU] = 1'b1;
      end else if (lsu_valid) begin
        grant[GNT_LSU] = 1'b1;
      end
    end
  end

  // Counts consecutive denials of a waiting EXU; frozen while hold is high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_cnt <= '0;
    end else if (!hold) begin
      if (!exu_valid || grant[GNT_EXU]) begin
        starve_cnt <= '0;
      end else if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ysyx_23060096_wbu.sv
// Write-back unit: sole writer of the register-file port. Arbitrates EXU/LSU
// results into one registered write per cycle and counts retirements.
module ysyx_23060096_wbu
  import ysyx_23060096_pkg::*;
#(
  parameter int DATA_WIDTH   = WB_DATA_W,
  parameter int ADDR_WIDTH   = WB_ADDR_W,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 hold,
  ysyx_23060096_wbu_if.slave                   src,
  output logic                                 rf_wen,
  output logic [ADDR_WIDTH-1:0]                rf_waddr,
  output logic [DATA_WIDTH-1:0]                rf_wdata,
  output logic                                 commit,
  output logic [63:0]                          commit_cnt,
  output logic [1:0]                           dbg_grant,
  output logic [$clog2(STARVE_LIMIT+1)-1:0]    dbg_starve_cnt
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [1:0]            grant;
  logic [CNT_W-1:0]      starve_cnt;
  logic                  accept;
  logic                  sel_wen;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [63:0]           cnt_q;

  ysyx_23060096_wb_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_arbiter (
    .clk        (clk),
    .rstn       (rstn),
    .hold       (hold),
    .exu_valid  (src.exu_valid),
    .lsu_valid  (src.lsu_valid),
    .grant      (grant),
    .starve_cnt (starve_cnt)
  );

  assign src.exu_ready  = grant[GNT_EXU];
  assign src.lsu_ready  = grant[GNT_LSU];
  assign dbg_grant      = grant;
  assign dbg_starve_cnt = starve_cnt;
  assign commit_cnt     = cnt_q;

  always_comb begin
    accept   = grant[GNT_EXU] | grant[GNT_LSU];
    sel_wen  = src.exu_wen;
    sel_rd   = src.exu_rd;
    sel_data = src.exu_data;
    if (grant[GNT_LSU]) begin
      sel_wen  = src.lsu_wen;
      sel_rd   = src.lsu_rd;
      sel_data = src.lsu_data;
    end
  end

  // Single-entry output stage: it is rewritten or cleared every cycle, so the
  // register file never needs to push back.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      commit   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      rf_wen <= accept && sel_wen && (sel_rd != ADDR_WIDTH'(REG_ZERO));
      commit <= accept;
      if (accept) begin
        rf_waddr <= sel_rd;
        rf_wdata <= sel_data;
        cnt_q    <= cnt_q + 64'd1;
      end
    end
  end

endmodule
